// File: rtl/systemverilog_str_demux.sv
// Byte-stream to bus-write deserializer.
// Gathers 8-byte packets (data bytes first, then address bytes, each LSB first)
// from a valid/ready byte stream and issues one valid/ready bus write per packet.
// A second packet may be assembled while the previous bus write is still pending.
// A partial packet that stalls mid-way is dropped after an idle timeout.
module systemverilog_str_demux #(
    parameter int IDLE_TMO = 16,
    parameter int TMO_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        str_vld,
    input  logic [7:0]  str_bus,
    output logic        str_rdy,
    output logic        bus_vld,
    output logic [31:0] bus_adr,
    output logic [31:0] bus_dat,
    input  logic        bus_rdy,
    output logic        err_tmo
);

    // A zero timeout disables the idle drop entirely.
    localparam bit               TMO_EN   = (IDLE_TMO != 0);
    // The drop fires in the last idle cycle, so compare against IDLE_TMO-1.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(IDLE_TMO - 1);

    logic [2:0]       byte_cnt;
    logic [63:0]      asm_buf;
    logic             asm_full;
    logic [TMO_W-1:0] tmo_cnt;

    logic             str_trn;
    logic             out_free;
    logic             pkt_done;
    logic             tmo_hit;
    logic [63:0]      pkt_word;

    assign str_rdy  = ~asm_full & ~rst;
    assign str_trn  = str_vld & str_rdy;
    assign out_free = ~bus_vld | bus_rdy;
    assign pkt_done = str_trn & (byte_cnt == 3'd7);
    // Complete packet including the byte being accepted this cycle.
    assign pkt_word = {str_bus, asm_buf[55:0]};
    // A byte arriving in the expiry cycle wins over the timeout.
    assign tmo_hit  = TMO_EN && (byte_cnt != 3'd0) && !str_trn && (tmo_cnt == TMO_LAST);

    // Byte assembly: each accepted byte lands in its slot; the counter wraps after byte 7.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt <= 3'd0;
            asm_buf  <= 64'd0;
        end else if (str_trn) begin
            asm_buf[{byte_cnt, 3'b000} +: 8] <= str_bus;
            byte_cnt                         <= byte_cnt + 3'd1;
        end else if (tmo_hit) begin
            byte_cnt <= 3'd0;
        end
    end

    // Idle timeout: counts stalled cycles inside a packet and flags a drop for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
            err_tmo <= 1'b0;
        end else begin
            err_tmo <= tmo_hit;
            if (!TMO_EN || str_trn || (byte_cnt == 3'd0) || tmo_hit) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    // Output stage: loads the buffered packet first, else a just-completed one, else parks it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_vld  <= 1'b0;
            bus_adr  <= 32'd0;
            bus_dat  <= 32'd0;
            asm_full <= 1'b0;
        end else if (asm_full && out_free) begin
            bus_adr  <= asm_buf[63:32];
            bus_dat  <= asm_buf[31:0];
            bus_vld  <= 1'b1;
            asm_full <= 1'b0;
        end else if (pkt_done && out_free) begin
            bus_adr <= pkt_word[63:32];
            bus_dat <= pkt_word[31:0];
            bus_vld <= 1'b1;
        end else begin
            if (pkt_done) begin
                asm_full <= 1'b1;
            end
            if (bus_vld && bus_rdy) begin
                bus_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_systemverilog_str_demux.sv
// Directed and randomised bench for the byte-stream to bus-write deserializer.
module tb_systemverilog_str_demux;

    logic        clk;
    logic        rst;
    logic        str_vld;
    logic [7:0]  str_bus;
    logic        str_rdy;
    logic        bus_vld;
    logic [31:0] bus_adr;
    logic [31:0] bus_dat;
    logic        bus_rdy;
    logic        err_tmo;

    int checks;
    int errors;
    int err_seen;
    int vld_seen;
    logic [63:0] captured[$];
    logic [63:0] expected[$];

    systemverilog_str_demux #(.IDLE_TMO(16), .TMO_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .str_vld (str_vld),
        .str_bus (str_bus),
        .str_rdy (str_rdy),
        .bus_vld (bus_vld),
        .bus_adr (bus_adr),
        .bus_dat (bus_dat),
        .bus_rdy (bus_rdy),
        .err_tmo (err_tmo)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus and error monitor, sampled on the falling edge between drive points.
    always @(negedge clk) begin
        if (!rst && bus_vld && bus_rdy) captured.push_back({bus_adr, bus_dat});
        if (!rst && bus_vld) vld_seen++;
        if (!rst && err_tmo) err_seen++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offers one byte and returns just after the edge that accepted it.
    task automatic send_byte(input logic [7:0] b);
        int w;
        w = 0;
        str_vld = 1'b1;
        str_bus = b;
        @(negedge clk);
        while (!str_rdy && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (!str_rdy) begin
            checks++;
            errors++;
            $display("[TB] FAIL str_rdy_wait: got str_rdy=%b expected 1 within 500 cycles", str_rdy);
        end
        @(posedge clk);
        #1;
        str_vld = 1'b0;
    endtask

    task automatic send_packet(input logic [31:0] adr, input logic [31:0] dat);
        for (int i = 0; i < 4; i++) send_byte(dat[8*i +: 8]);
        for (int i = 0; i < 4; i++) send_byte(adr[8*i +: 8]);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        checks++; if (bus_vld !== 1'b0) begin errors++; $display("[TB] FAIL reset_bus_vld: got %b expected 0", bus_vld); end
        checks++; if (bus_adr !== 32'd0) begin errors++; $display("[TB] FAIL reset_bus_adr: got %h expected 00000000", bus_adr); end
        checks++; if (bus_dat !== 32'd0) begin errors++; $display("[TB] FAIL reset_bus_dat: got %h expected 00000000", bus_dat); end
        checks++; if (err_tmo !== 1'b0) begin errors++; $display("[TB] FAIL reset_err_tmo: got %b expected 0", err_tmo); end
        checks++; if (str_rdy !== 1'b0) begin errors++; $display("[TB] FAIL reset_str_rdy: got %b expected 0", str_rdy); end
        rst = 1'b0;
        #1;
        checks++; if (str_rdy !== 1'b1) begin errors++; $display("[TB] FAIL release_str_rdy: got %b expected 1", str_rdy); end
    endtask

    task automatic test_single_packet();
        logic [7:0] bytes [8];
        int v0;
        bytes = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        bus_rdy = 1'b1;
        v0 = vld_seen;
        for (int i = 0; i < 8; i++) send_byte(bytes[i]);
        checks++; if (bus_vld !== 1'b1) begin errors++; $display("[TB] FAIL single_vld: got %b expected 1", bus_vld); end
        checks++; if (bus_adr !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL single_adr: got %h expected deadbeef", bus_adr); end
        checks++; if (bus_dat !== 32'h12345678) begin errors++; $display("[TB] FAIL single_dat: got %h expected 12345678", bus_dat); end
        step(2);
        checks++; if (vld_seen - v0 !== 1) begin errors++; $display("[TB] FAIL single_vld_cycles: got %0d expected 1", vld_seen - v0); end
        checks++; if (bus_vld !== 1'b0) begin errors++; $display("[TB] FAIL single_vld_drop: got %b expected 0", bus_vld); end
    endtask

    task automatic test_back_to_back();
        bus_rdy = 1'b0;
        send_packet(32'hA0A1A2A3, 32'hB0B1B2B3);
        send_packet(32'hC0C1C2C3, 32'hD0D1D2D3);
        step(2);
        checks++; if (bus_vld !== 1'b1) begin errors++; $display("[TB] FAIL bp_vld_a: got %b expected 1", bus_vld); end
        checks++; if (bus_adr !== 32'hA0A1A2A3) begin errors++; $display("[TB] FAIL bp_adr_a: got %h expected a0a1a2a3", bus_adr); end
        checks++; if (bus_dat !== 32'hB0B1B2B3) begin errors++; $display("[TB] FAIL bp_dat_a: got %h expected b0b1b2b3", bus_dat); end
        checks++; if (str_rdy !== 1'b0) begin errors++; $display("[TB] FAIL bp_str_rdy_full: got %b expected 0", str_rdy); end
        bus_rdy = 1'b1;
        step(1);
        bus_rdy = 1'b0;
        checks++; if (bus_vld !== 1'b1) begin errors++; $display("[TB] FAIL bp_vld_b: got %b expected 1", bus_vld); end
        checks++; if (bus_adr !== 32'hC0C1C2C3) begin errors++; $display("[TB] FAIL bp_adr_b: got %h expected c0c1c2c3", bus_adr); end
        checks++; if (bus_dat !== 32'hD0D1D2D3) begin errors++; $display("[TB] FAIL bp_dat_b: got %h expected d0d1d2d3", bus_dat); end
        checks++; if (str_rdy !== 1'b1) begin errors++; $display("[TB] FAIL bp_str_rdy_free: got %b expected 1", str_rdy); end
        bus_rdy = 1'b1;
        step(1);
        checks++; if (bus_vld !== 1'b0) begin errors++; $display("[TB] FAIL bp_drain: got %b expected 0", bus_vld); end
    endtask

    task automatic test_timeout();
        int e0;
        int v0;
        bus_rdy = 1'b1;
        e0 = err_seen;
        v0 = vld_seen;
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        step(15);
        checks++; if (err_tmo !== 1'b0) begin errors++; $display("[TB] FAIL tmo_early: got %b expected 0", err_tmo); end
        step(1);
        checks++; if (err_tmo !== 1'b1) begin errors++; $display("[TB] FAIL tmo_pulse: got %b expected 1", err_tmo); end
        step(1);
        checks++; if (err_tmo !== 1'b0) begin errors++; $display("[TB] FAIL tmo_single: got %b expected 0", err_tmo); end
        step(3);
        checks++; if (err_seen - e0 !== 1) begin errors++; $display("[TB] FAIL tmo_count: got %0d expected 1", err_seen - e0); end
        checks++; if (vld_seen - v0 !== 0) begin errors++; $display("[TB] FAIL tmo_no_vld: got %0d expected 0", vld_seen - v0); end
        send_packet(32'h11223344, 32'h55667788);
        checks++; if (bus_vld !== 1'b1) begin errors++; $display("[TB] FAIL tmo_next_vld: got %b expected 1", bus_vld); end
        checks++; if (bus_adr !== 32'h11223344) begin errors++; $display("[TB] FAIL tmo_next_adr: got %h expected 11223344", bus_adr); end
        checks++; if (bus_dat !== 32'h55667788) begin errors++; $display("[TB] FAIL tmo_next_dat: got %h expected 55667788", bus_dat); end
        step(1);
    endtask

    task automatic test_timeout_boundary();
        int e0;
        bus_rdy = 1'b1;
        e0 = err_seen;
        send_byte(8'h44);
        send_byte(8'h33);
        send_byte(8'h22);
        step(15);
        send_byte(8'h11);
        send_byte(8'hDD);
        send_byte(8'hCC);
        send_byte(8'hBB);
        send_byte(8'hAA);
        checks++; if (bus_vld !== 1'b1) begin errors++; $display("[TB] FAIL edge_vld: got %b expected 1", bus_vld); end
        checks++; if (bus_adr !== 32'hAABBCCDD) begin errors++; $display("[TB] FAIL edge_adr: got %h expected aabbccdd", bus_adr); end
        checks++; if (bus_dat !== 32'h11223344) begin errors++; $display("[TB] FAIL edge_dat: got %h expected 11223344", bus_dat); end
        step(2);
        checks++; if (err_seen - e0 !== 0) begin errors++; $display("[TB] FAIL edge_no_err: got %0d expected 0", err_seen - e0); end
    endtask

    task automatic test_reset_mid_packet();
        int v0;
        bus_rdy = 1'b0;
        send_packet(32'h0BADF00D, 32'hCAFEBABE);
        for (int i = 0; i < 5; i++) send_byte(8'h90 + 8'(i));
        rst = 1'b1;
        #1;
        checks++; if (bus_vld !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_vld: got %b expected 0", bus_vld); end
        checks++; if (str_rdy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_str_rdy: got %b expected 0", str_rdy); end
        step(2);
        rst = 1'b0;
        #1;
        checks++; if (str_rdy !== 1'b1) begin errors++; $display("[TB] FAIL rstrel_str_rdy: got %b expected 1", str_rdy); end
        bus_rdy = 1'b1;
        v0 = vld_seen;
        step(3);
        checks++; if (vld_seen - v0 !== 0) begin errors++; $display("[TB] FAIL rstrel_spurious_vld: got %0d expected 0", vld_seen - v0); end
        send_packet(32'h87654321, 32'h0F1E2D3C);
        checks++; if (bus_adr !== 32'h87654321) begin errors++; $display("[TB] FAIL rstrel_adr: got %h expected 87654321", bus_adr); end
        checks++; if (bus_dat !== 32'h0F1E2D3C) begin errors++; $display("[TB] FAIL rstrel_dat: got %h expected 0f1e2d3c", bus_dat); end
        step(1);
    endtask

    task automatic test_random_throttle();
        int n;
        int w;
        bit done;
        logic [31:0] a;
        logic [31:0] d;
        n = 1000;
        done = 1'b0;
        bus_rdy = 1'b1;
        step(2);
        captured.delete();
        expected.delete();
        fork
            begin
                for (int p = 0; p < n; p++) begin
                    a = $urandom;
                    d = $urandom;
                    expected.push_back({a, d});
                    for (int i = 0; i < 8; i++) begin
                        send_byte(i < 4 ? d[8*i +: 8] : a[8*(i-4) +: 8]);
                        if ($urandom_range(0, 3) == 0) step($urandom_range(1, 3));
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    bus_rdy = ($urandom_range(0, 2) != 0);
                end
            end
        join
        bus_rdy = 1'b1;
        w = 0;
        while (captured.size() < n && w < 200) begin
            step(1);
            w++;
        end
        step(3);
        checks++;
        if (captured.size() !== n) begin
            errors++;
            $display("[TB] FAIL rand_count: got %0d transfers expected %0d", captured.size(), n);
        end
        for (int i = 0; i < n && i < captured.size(); i++) begin
            checks++;
            if (captured[i] !== expected[i]) begin
                errors++;
                $display("[TB] FAIL rand_pkt_%0d: got %h expected %h", i, captured[i], expected[i]);
            end
        end
    endtask

    // Test sequence.
    initial begin
        checks   = 0;
        errors   = 0;
        err_seen = 0;
        vld_seen = 0;
        rst      = 1'b1;
        str_vld  = 1'b0;
        str_bus  = 8'h00;
        bus_rdy  = 1'b0;
        test_reset();
        test_single_packet();
        test_back_to_back();
        test_timeout();
        test_timeout_boundary();
        test_reset_mid_packet();
        test_random_throttle();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
